row_packer: RTL and testbench
=============================

ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bits per matrix element (fixed-point).
REQ-002 SHALL have parameter COL, default 256, elements per matrix row.
REQ-003 SHALL have parameter ROW, default 2754, rows per matrix (frame).
REQ-004 SHALL have parameter BEAT_ELEMS, default 4, elements per input beat; COL % BEAT_ELEMS == 0.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port s_valid  input  1  input beat valid.
REQ-008 SHALL have port s_ready  output  1  input beat accepted when s_valid && s_ready.
REQ-009 SHALL have port s_data  input  WIDTH*BEAT_ELEMS  beat, element 0 in MSBs.
REQ-010 SHALL have port row_valid  output  1  packed row available.
REQ-011 SHALL have port row_ready  input  1  consumer (n2r buffer) takes row when row_valid && row_ready.
REQ-012 SHALL have port row_data  output  WIDTH*COL  packed row, column 0 in MSBs [WIDTH*COL-1 -: WIDTH].
REQ-013 SHALL have port row_idx  output  $clog2(ROW)  index of row on row_data, 0..ROW-1.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after last row of frame handed off.

Function
REQ-015 SHALL pack BEATS = COL/BEAT_ELEMS consecutive accepted beats into one row; beat k fills columns k*BEAT_ELEMS..k*BEAT_ELEMS+BEAT_ELEMS-1, beat element order preserved.
REQ-016 SHALL hold an assembly register and one output register (two-entry: fill + hold).
REQ-017 SHALL keep beat counter beat_cnt, 0..BEATS-1, incremented per accepted beat, wrapping to 0 on the last beat.
REQ-018 SHALL, on acceptance of the last beat, transfer the completed row to the output register the same edge; row_valid asserts the following cycle (latency 1 cycle from last beat).
REQ-019 SHALL drive s_ready = !(beat_cnt == BEATS-1 && row_valid && !row_ready); all non-final beats accepted regardless of output state.
REQ-020 SHALL, when last beat accepted and row handed off in the same cycle, load the new row and keep row_valid high (no bubble).
REQ-021 SHALL hold row_data, row_idx stable while row_valid && !row_ready.
REQ-022 SHALL deassert row_valid after handoff unless a new row loads that edge.
REQ-023 SHALL keep row counter, incremented on each handoff, wrapping from ROW-1 to 0; row_idx reflects the output register's row.
REQ-024 SHALL pulse frame_done for exactly one cycle, the cycle after handoff of row_idx == ROW-1.
REQ-025 SHALL ignore s_data when s_valid low; s_valid with s_ready low SHALL not advance beat_cnt.
REQ-026 SHALL support BEATS == 1 (COL == BEAT_ELEMS): every accepted beat is a row.

Reset
REQ-027 SHALL, on rst high at a clock edge, clear beat_cnt, row counter, row_valid, frame_done; row_data and row_idx SHALL read 0.
REQ-028 SHALL discard any partially assembled row on reset mid-operation; s_ready SHALL be 1 the cycle after reset releases.
REQ-029 SHALL give reset priority over any simultaneous handshake.

Structure
REQ-030 SHALL place BEATS, BEAT_CNT_W, ROW_IDX_W derivations in the shared matmul package alongside the WIDTH/COL/ROW constants used by the n2r buffer.
REQ-031 SHALL be a single module with no sub-modules; output register is a plain valid/ready hold stage.

Verification (WIDTH=16, COL=4, BEAT_ELEMS=2, ROW=3)
REQ-032 Streaming: beats 0x0001_0002, 0x0003_0004, row_ready=1 -> row_data=0x0001_0002_0003_0004, row_idx=0, row_valid one cycle after second beat.
REQ-033 Backpressure: row_ready=0 with row 0 held, send 3 beats -> beat 3 accepted, beat 4 stalls (s_ready=0), row_data unchanged; release row_ready -> row 1 appears next cycle, no data lost.
REQ-034 Simultaneous: last beat of row 1 accepted in same cycle row 0 handed off -> row_valid stays 1, row_idx 0 -> 1, no gap.
REQ-035 Frame wrap: 3 rows handed off -> frame_done single pulse after row_idx=2 handoff; next row row_idx=0.
REQ-036 Reset mid-row: one beat accepted, rst pulse, then beats 0x000A_000B, 0x000C_000D -> row_data=0x000A_000B_000C_000D, row_idx=0.
REQ-037 Idle gaps: random s_valid deassertion -> beats counted only on handshake; output identical to REQ-032.

Source files
------------

// File: rtl/row_packer_pkg.sv
// Shared matmul constants and the width/beat derivations used by the row packer
// and the n2r buffer that consumes its rows.
package row_packer_pkg;

   localparam int WIDTH_DEF      = 16;
   localparam int COL_DEF        = 256;
   localparam int ROW_DEF        = 2754;
   localparam int BEAT_ELEMS_DEF = 4;

   function automatic int calc_beats(input int col, input int beat_elems);
      return col / beat_elems;
   endfunction

   // Counter width that never collapses to zero bits when only one value exists.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BEATS_DEF      = calc_beats(COL_DEF, BEAT_ELEMS_DEF);
   localparam int BEAT_CNT_W_DEF = cnt_width(BEATS_DEF);
   localparam int ROW_IDX_W_DEF  = cnt_width(ROW_DEF);

endpackage

// File: rtl/row_packer_if.sv
// Beat input and packed-row output of the row packer. Both sides use valid/ready:
// a transfer happens on a rising edge where valid && ready; the sender holds data stable while valid && !ready.
interface row_packer_if #(
   parameter int WIDTH      = 16,
   parameter int COL        = 256,
   parameter int ROW        = 2754,
   parameter int BEAT_ELEMS = 4
) ();

   localparam int ROW_IDX_W = row_packer_pkg::cnt_width(ROW);

   logic                          s_valid;
   logic                          s_ready;
   logic [WIDTH*BEAT_ELEMS-1:0]   s_data;
   logic                          row_valid;
   logic                          row_ready;
   logic [WIDTH*COL-1:0]          row_data;
   logic [ROW_IDX_W-1:0]          row_idx;
   logic                          frame_done;

   modport slave (
      input  s_valid, s_data, row_ready,
      output s_ready, row_valid, row_data, row_idx, frame_done
   );

   modport master (
      output s_valid, s_data, row_ready,
      input  s_ready, row_valid, row_data, row_idx, frame_done
   );

endinterface

// File: rtl/row_packer.sv
// Packs BEATS consecutive input beats into one matrix row, with an assembly
// register feeding a single valid/ready hold register for the finished row.
module row_packer
   import row_packer_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int COL        = COL_DEF,
   parameter int ROW        = ROW_DEF,
   parameter int BEAT_ELEMS = BEAT_ELEMS_DEF
) (
   input  logic           clk,
   input  logic           rst,
   row_packer_if.slave    bus
);

   localparam int BEATS      = calc_beats(COL, BEAT_ELEMS);
   localparam int BEAT_CNT_W = cnt_width(BEATS);
   localparam int ROW_IDX_W  = cnt_width(ROW);
   localparam int BEAT_BITS  = WIDTH * BEAT_ELEMS;
   localparam int ROW_BITS   = WIDTH * COL;

   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
   localparam logic [ROW_IDX_W-1:0]  LAST_ROW  = ROW_IDX_W'(ROW - 1);

   logic [BEAT_CNT_W-1:0] beat_cnt;
   logic [ROW_IDX_W-1:0]  row_cnt;
   logic [ROW_BITS-1:0]   asm_row;
   logic [ROW_BITS-1:0]   row_next;
   logic [ROW_BITS-1:0]   out_row;
   logic                  out_valid;
   logic                  done_q;
   logic                  last_beat;
   logic                  accept;
   logic                  last_accept;
   logic                  handoff;

   assign last_beat   = (beat_cnt == LAST_BEAT);
   // Only the closing beat needs room in the hold register; earlier beats always fit.
   assign bus.s_ready = !(last_beat && out_valid && !bus.row_ready);
   assign accept      = bus.s_valid && bus.s_ready;
   assign last_accept = accept && last_beat;
   assign handoff     = out_valid && bus.row_ready;

   // Drop the incoming beat into its column slot; beat 0 lands in the MSBs.
   always_comb begin
      row_next = asm_row;
      for (int k = 0; k < BEATS; k++) begin
         if (beat_cnt == BEAT_CNT_W'(k)) begin
            row_next[ROW_BITS-1-k*BEAT_BITS -: BEAT_BITS] = bus.s_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt  <= '0;
         row_cnt   <= '0;
         asm_row   <= '0;
         out_row   <= '0;
         out_valid <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= handoff && (row_cnt == LAST_ROW);

         if (accept) begin
            asm_row  <= row_next;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
         end

         // row_cnt names the row sitting in the hold register, so it advances on handoff.
         if (handoff) begin
            row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
         end

         if (last_accept) begin
            out_row   <= row_next;
            out_valid <= 1'b1;
         end else if (handoff) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.row_valid  = out_valid;
   assign bus.row_data   = out_row;
   assign bus.row_idx    = row_cnt;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_row_packer.sv
// Bench for row_packer at WIDTH=16, COL=4, BEAT_ELEMS=2, ROW=3: vector table,
// hand-written corner sequences and a randomized run against an element-queue model.
module tb_row_packer;

   localparam int W     = 16;
   localparam int C     = 4;
   localparam int BE    = 2;
   localparam int R     = 3;
   localparam int BW    = W * BE;
   localparam int RW    = W * C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   row_packer_if #(.WIDTH(W), .COL(C), .ROW(R), .BEAT_ELEMS(BE)) bus ();

   row_packer #(.WIDTH(W), .COL(C), .ROW(R), .BEAT_ELEMS(BE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: elements accepted so far for the row in progress, and finished rows awaiting handoff.
   logic [W-1:0]  elem_q[$];
   logic [RW-1:0] exp_q[$];
   int            exp_idx;
   bit            exp_fd;

   typedef struct {
      logic [BW-1:0] b0;
      logic [BW-1:0] b1;
      logic [RW-1:0] row;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      elem_q.delete();
      exp_q.delete();
      exp_idx = 0;
      exp_fd  = 1'b0;
   endtask

   // One clock cycle: apply inputs, compare outputs against the model, advance across the edge.
   task automatic step(input logic v, input logic [BW-1:0] d, input logic rr);
      bit            acc;
      bit            hand;
      bit            exp_rdy;
      logic [RW-1:0] r;
      bus.s_valid   = v;
      bus.s_data    = d;
      bus.row_ready = rr;
      #1;
      // The closing beat of a row needs the hold slot to be empty or emptying this cycle.
      exp_rdy = !((elem_q.size() == C - BE) && (exp_q.size() != 0) && !rr);
      chk("s_ready", RW'(bus.s_ready), RW'(exp_rdy));
      chk("row_valid", RW'(bus.row_valid), RW'(exp_q.size() != 0));
      chk("frame_done", RW'(bus.frame_done), RW'(exp_fd));
      if (exp_q.size() != 0) begin
         chk("row_data", bus.row_data, exp_q[0]);
         chk("row_idx", RW'(bus.row_idx), RW'(exp_idx));
      end
      acc  = v && exp_rdy;
      hand = (exp_q.size() != 0) && rr;
      @(posedge clk);
      #1;
      exp_fd = 1'b0;
      if (hand) begin
         void'(exp_q.pop_front());
         exp_fd  = (exp_idx == R - 1);
         exp_idx = (exp_idx + 1) % R;
      end
      if (acc) begin
         for (int e = 0; e < BE; e++) elem_q.push_back(d[BW-1-e*W -: W]);
         if (elem_q.size() == C) begin
            r = '0;
            for (int c = 0; c < C; c++) r = {r[RW-W-1:0], elem_q.pop_front()};
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic do_reset(input logic v);
      rst           = 1'b1;
      bus.s_valid   = v;
      bus.s_data    = BW'($urandom);
      bus.row_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.s_valid   = 1'b0;
      bus.row_ready = 1'b0;
      model_reset();
      #1;
      chk("rst_row_valid", RW'(bus.row_valid), '0);
      chk("rst_frame_done", RW'(bus.frame_done), '0);
      chk("rst_row_data", bus.row_data, '0);
      chk("rst_row_idx", RW'(bus.row_idx), '0);
      chk("rst_s_ready", RW'(bus.s_ready), RW'(1));
   endtask

   initial begin
      int fd_cnt;
      int gap;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.row_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      // Streaming vectors with row_ready held high.
      tbl[0] = '{32'h0001_0002, 32'h0003_0004, 64'h0001_0002_0003_0004};
      tbl[1] = '{32'hFFFF_8000, 32'h0000_7FFF, 64'hFFFF_8000_0000_7FFF};
      tbl[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
      tbl[3] = '{32'h000A_000B, 32'h000C_000D, 64'h000A_000B_000C_000D};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, tbl[i].b0, 1'b1);
         step(1'b1, tbl[i].b1, 1'b1);
         chk("tbl_valid", RW'(bus.row_valid), RW'(1));
         chk("tbl_row", bus.row_data, tbl[i].row);
         chk("tbl_idx", RW'(bus.row_idx), RW'(i % R));
      end
      step(1'b0, '0, 1'b1);

      // Backpressure, then last beat accepted in the same cycle as handoff.
      do_reset(1'b1);
      step(1'b1, 32'h0001_0002, 1'b0);
      step(1'b1, 32'h0003_0004, 1'b0);
      step(1'b1, 32'h1111_2222, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h3333_4444, 1'b0);
         chk("bp_stall", RW'(bus.s_ready), '0);
         chk("bp_hold", bus.row_data, 64'h0001_0002_0003_0004);
      end
      step(1'b1, 32'h3333_4444, 1'b1);
      chk("sim_valid", RW'(bus.row_valid), RW'(1));
      chk("sim_idx", RW'(bus.row_idx), RW'(1));
      chk("sim_row", bus.row_data, 64'h1111_2222_3333_4444);
      step(1'b0, '0, 1'b1);

      // Frame wrap: exactly one frame_done pulse over three rows, then index restarts.
      do_reset(1'b0);
      fd_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, BW'($urandom), 1'b1);
         fd_cnt += int'(bus.frame_done);
         step(1'b1, BW'($urandom), 1'b1);
         fd_cnt += int'(bus.frame_done);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0, 1'b1);
         fd_cnt += int'(bus.frame_done);
      end
      chk("fd_pulses", RW'(fd_cnt), RW'(1));
      step(1'b1, 32'h5555_6666, 1'b0);
      step(1'b1, 32'h7777_8888, 1'b0);
      chk("wrap_idx", RW'(bus.row_idx), '0);
      step(1'b0, '0, 1'b1);

      // Reset mid-row discards the partial beat; reset wins over a live handshake.
      do_reset(1'b0);
      step(1'b1, 32'hDEAD_BEEF, 1'b1);
      do_reset(1'b1);
      step(1'b1, 32'h000A_000B, 1'b1);
      step(1'b1, 32'h000C_000D, 1'b1);
      chk("mid_rst_row", bus.row_data, 64'h000A_000B_000C_000D);
      chk("mid_rst_idx", RW'(bus.row_idx), '0);
      step(1'b0, '0, 1'b1);

      // Idle gaps between beats do not change the packed row.
      do_reset(1'b0);
      gap = $urandom_range(1, 4);
      repeat (gap) step(1'b0, BW'($urandom), 1'b1);
      step(1'b1, 32'h0001_0002, 1'b1);
      gap = $urandom_range(1, 4);
      repeat (gap) step(1'b0, BW'($urandom), 1'b1);
      step(1'b1, 32'h0003_0004, 1'b1);
      chk("gap_row", bus.row_data, 64'h0001_0002_0003_0004);
      chk("gap_idx", RW'(bus.row_idx), '0);
      step(1'b0, '0, 1'b1);

      // Randomized valid, ready and data against the model.
      do_reset(1'b0);
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom_range(0, 1)), BW'($urandom), ($urandom_range(0, 3) != 0));
      end
      repeat (4) step(1'b0, '0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
